timer_bank: RTL and testbench

Parametrised bank of independent memory-mapped interval timers on the CPU peripheral bus at 0x4000_0100. Each channel has a reload value, an up-counter, periodic or one-shot mode, and a write-1-to-clear pending flag with a per-channel enable. Adds multi-channel support, one-shot mode, interrupt clearing and a summary register to the single-timer peripheral. Channel interrupts are OR-ed onto the CPU interrupt line.

---
 rtl/timer_bank_pkg.sv | 31 +++
 rtl/timer_channel.sv | 68 ++++++
 rtl/timer_bank.sv | 90 +++++++++
 tb/tb_timer_bank.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_bank_pkg.sv
// Shared definitions for the timer bank: register map, TCON layout and a
// helper that extracts the TCON fields from a bus write word.
package timer_bank_pkg;

  localparam logic [3:0] OFF_TH   = 4'h0;
  localparam logic [3:0] OFF_TL   = 4'h4;
  localparam logic [3:0] OFF_TCON = 4'h8;
  localparam logic [3:0] OFF_STAT = 4'hC;

  localparam int CH_STRIDE = 16;

  localparam int TCON_EN      = 0;
  localparam int TCON_IE      = 1;
  localparam int TCON_ONESHOT = 2;

  // Packed so that en lands on bit 0, ie on bit 1, oneshot on bit 2.
  typedef struct packed {
    logic oneshot;
    logic ie;
    logic en;
  } tcon_t;

  function automatic tcon_t to_tcon(input logic [31:0] d);
    tcon_t t;
    t.oneshot = d[TCON_ONESHOT];
    t.ie      = d[TCON_IE];
    t.en      = d[TCON_EN];
    return t;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One interval timer: reload (TH), up-counter (TL), control (TCON) and a
// sticky pending flag. Resolves all same-cycle write/count collisions.
module timer_channel
  import timer_bank_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             th_we,
  input  logic             tl_we,
  input  logic             tcon_we,
  input  logic             stat_we,
  input  logic [31:0]      wdata,
  output logic [WIDTH-1:0] th,
  output logic [WIDTH-1:0] tl,
  output logic [2:0]       tcon,
  output logic             pend,
  output logic             irq
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  tcon_t tcon_q;
  logic  overflow;

  // An overflow is a counting cycle that finds the counter at all-ones.
  assign overflow = tcon_q.en && (tl == ALL_ONES);

  // Register update; bus writes beat counting, overflow beats clearing.
  always_ff @(posedge clk) begin
    if (!reset) begin
      th     <= '0;
      tl     <= ALL_ONES;
      tcon_q <= '0;
      pend   <= 1'b0;
    end else begin
      if (th_we) begin
        th <= wdata[WIDTH-1:0];
      end

      if (tl_we) begin
        tl <= wdata[WIDTH-1:0];
      end else if (overflow) begin
        tl <= th;
      end else if (tcon_q.en) begin
        tl <= tl + ONE;
      end

      if (tcon_we) begin
        tcon_q <= to_tcon(wdata);
      end else if (overflow && tcon_q.oneshot) begin
        tcon_q.en <= 1'b0;
      end

      if (overflow) begin
        pend <= 1'b1;
      end else if (stat_we && wdata[0]) begin
        pend <= 1'b0;
      end
    end
  end

  assign tcon = tcon_q;
  assign irq  = pend && tcon_q.ie;

endmodule

// File: rtl/timer_bank.sv
// Bank of NUM_CH memory-mapped interval timers with a read-only pending
// summary word and a single OR-ed interrupt line.
module timer_bank
  import timer_bank_pkg::*;
#(
  parameter int          NUM_CH    = 4,
  parameter int          WIDTH     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h40000100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              read_acc,
  output logic              write_acc,
  output logic [NUM_CH-1:0] irq,
  output logic              interrupt
);

  localparam logic [31:0] SUMMARY_ADDR = BASE_ADDR + 32'(CH_STRIDE * NUM_CH);

  logic [31:0] offset;
  logic [27:0] ch_sel;
  logic [3:0]  reg_off;
  logic        in_chan;
  logic        is_summary;

  logic [WIDTH-1:0] th_arr   [NUM_CH];
  logic [WIDTH-1:0] tl_arr   [NUM_CH];
  logic [2:0]       tcon_arr [NUM_CH];
  logic [NUM_CH-1:0] pend_vec;

  // Addresses below the base wrap to huge offsets and so fall out of range.
  assign offset     = addr - BASE_ADDR;
  assign ch_sel     = offset[31:4];
  assign reg_off    = offset[3:0];
  assign in_chan    = (ch_sel < 28'(NUM_CH)) && (reg_off[1:0] == 2'b00);
  assign is_summary = (addr == SUMMARY_ADDR);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic hit;
    assign hit = write && in_chan && (ch_sel == 28'(c));

    timer_channel #(.WIDTH(WIDTH)) u_channel (
      .clk     (clk),
      .reset   (reset),
      .th_we   (hit && (reg_off == OFF_TH)),
      .tl_we   (hit && (reg_off == OFF_TL)),
      .tcon_we (hit && (reg_off == OFF_TCON)),
      .stat_we (hit && (reg_off == OFF_STAT)),
      .wdata   (wdata),
      .th      (th_arr[c]),
      .tl      (tl_arr[c]),
      .tcon    (tcon_arr[c]),
      .pend    (pend_vec[c]),
      .irq     (irq[c])
    );
  end

  // Read mux and access flags; narrow registers are zero-extended.
  always_comb begin
    rdata     = '0;
    read_acc  = 1'b0;
    write_acc = 1'b0;
    if (is_summary) begin
      rdata    = 32'(pend_vec);
      read_acc = read;
    end else if (in_chan) begin
      read_acc  = read;
      write_acc = write;
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_sel == 28'(c)) begin
          case (reg_off)
            OFF_TH:   rdata = 32'(th_arr[c]);
            OFF_TL:   rdata = 32'(tl_arr[c]);
            OFF_TCON: rdata = 32'(tcon_arr[c]);
            OFF_STAT: rdata = 32'(pend_vec[c]);
            default:  rdata = '0;
          endcase
        end
      end
    end
  end

  assign interrupt = |irq;

endmodule

// File: tb/tb_timer_bank.sv
// Scoreboard bench for timer_bank: bus operations queue their expected
// response, a negedge monitor pops and compares while a strobe is active.
module tb_timer_bank;

  localparam logic [31:0] C0  = 32'h40000100;
  localparam logic [31:0] C1  = 32'h40000110;
  localparam logic [31:0] C2  = 32'h40000120;
  localparam logic [31:0] C3  = 32'h40000130;
  localparam logic [31:0] SUM = 32'h40000140;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;

  logic [31:0] rdata, rdata8;
  logic        read_acc, read_acc8, write_acc, write_acc8;
  logic [3:0]  irq;
  logic [1:0]  irq8;
  logic        interrupt, interrupt8;
  logic        sel8 = 1'b0;

  logic [31:0] exp_rdata [$];
  logic        exp_racc  [$];
  logic        exp_ichk  [$];
  logic [4:0]  exp_irq   [$];
  string       exp_name  [$];
  logic        exp_wacc  [$];
  string       exp_wname [$];

  int checks = 0;
  int passed = 0;

  logic [31:0] m_rd, e_rd;
  logic        m_ra, m_wa, e_ra, e_wa, e_chk;
  logic [4:0]  m_irq, e_irq;
  string       e_nm;

  timer_bank dut (
    .clk(clk), .reset(reset), .read(read), .write(write), .addr(addr),
    .wdata(wdata), .rdata(rdata), .read_acc(read_acc), .write_acc(write_acc),
    .irq(irq), .interrupt(interrupt)
  );

  timer_bank #(.NUM_CH(2), .WIDTH(8), .BASE_ADDR(32'h40000100)) dut8 (
    .clk(clk), .reset(reset), .read(read), .write(write), .addr(addr),
    .wdata(wdata), .rdata(rdata8), .read_acc(read_acc8), .write_acc(write_acc8),
    .irq(irq8), .interrupt(interrupt8)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Drive one bus cycle starting just after a posedge; returns just after the next.
  task automatic apply_stimulus(input logic r, input logic w, input logic [31:0] a,
                                input logic [31:0] d, input logic rst_n);
    reset = rst_n;
    read  = r;
    write = w;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
    read  = 1'b0;
    write = 1'b0;
    reset = 1'b1;
  endtask

  task automatic push_read(input logic [31:0] a_data, input logic acc, input logic chk,
                           input logic [3:0] iv, input string nm);
    exp_rdata.push_back(a_data);
    exp_racc.push_back(acc);
    exp_ichk.push_back(chk);
    exp_irq.push_back({|iv, iv});
    exp_name.push_back(nm);
  endtask

  task automatic expect_read(input logic [31:0] a, input logic [31:0] d, input logic acc,
                             input logic chk, input logic [3:0] iv, input string nm);
    push_read(d, acc, chk, iv, nm);
    apply_stimulus(1'b1, 1'b0, a, 32'h0, 1'b1);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic wacc,
                          input string nm, input logic rst_n = 1'b1);
    exp_wacc.push_back(wacc);
    exp_wname.push_back(nm);
    apply_stimulus(1'b0, 1'b1, a, d, rst_n);
  endtask

  task automatic read_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] rd_exp, input logic [3:0] iv, input string nm);
    push_read(rd_exp, 1'b1, 1'b1, iv, nm);
    exp_wacc.push_back(1'b1);
    exp_wname.push_back(nm);
    apply_stimulus(1'b1, 1'b1, a, d, 1'b1);
  endtask

  // Monitor: compare the selected DUT against the head of the queues mid-cycle.
  always @(negedge clk) begin
    m_rd  = sel8 ? rdata8 : rdata;
    m_ra  = sel8 ? read_acc8 : read_acc;
    m_wa  = sel8 ? write_acc8 : write_acc;
    m_irq = {interrupt, irq};
    if (read) begin
      checks++;
      if (exp_rdata.size() == 0) begin
        $display("[TB] FAIL read_underflow: read seen with no expectation queued");
      end else begin
        e_rd  = exp_rdata.pop_front();
        e_ra  = exp_racc.pop_front();
        e_chk = exp_ichk.pop_front();
        e_irq = exp_irq.pop_front();
        e_nm  = exp_name.pop_front();
        if (m_rd === e_rd && m_ra === e_ra) passed++;
        else $display("[TB] FAIL %s: rdata=%h read_acc=%b, expected rdata=%h read_acc=%b",
                      e_nm, m_rd, m_ra, e_rd, e_ra);
        if (e_chk) begin
          checks++;
          if (m_irq === e_irq) passed++;
          else $display("[TB] FAIL %s_irq: {interrupt,irq}=%b, expected %b", e_nm, m_irq, e_irq);
        end
      end
    end
    if (write) begin
      checks++;
      if (exp_wacc.size() == 0) begin
        $display("[TB] FAIL write_underflow: write seen with no expectation queued");
      end else begin
        e_wa = exp_wacc.pop_front();
        e_nm = exp_wname.pop_front();
        if (m_wa === e_wa) passed++;
        else $display("[TB] FAIL %s_wacc: write_acc=%b, expected %b", e_nm, m_wa, e_wa);
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus with hand-computed expectations.
  initial begin
    #1;
    apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

    expect_read(C0 + 0,   32'h0,        1, 1, 4'h0, "rst_th0");
    expect_read(C0 + 4,   32'hFFFFFFFF, 1, 1, 4'h0, "rst_tl0");
    expect_read(C0 + 8,   32'h0,        1, 1, 4'h0, "rst_tcon0");
    expect_read(C0 + 12,  32'h0,        1, 1, 4'h0, "rst_stat0");
    expect_read(C3 + 4,   32'hFFFFFFFF, 1, 1, 4'h0, "rst_tl3");
    expect_read(SUM,      32'h0,        1, 1, 4'h0, "rst_summary");
    expect_read(32'h40000000, 32'h0,    0, 0, 4'h0, "unmapped_low");
    expect_read(32'h40000144, 32'h0,    0, 0, 4'h0, "after_summary");
    expect_read(32'h40000102, 32'h0,    0, 0, 4'h0, "unaligned");
    do_write(SUM, 32'hF, 0, "summary_wr");
    do_write(32'h40000000, 32'h1, 0, "unmapped_wr");

    // Periodic channel 1, period 4.
    do_write(C1 + 0, 32'hFFFFFFFC, 1, "p_th");
    do_write(C1 + 4, 32'hFFFFFFFC, 1, "p_tl");
    do_write(C1 + 8, 32'h3, 1, "p_tcon");
    expect_read(C1 + 4,  32'hFFFFFFFC, 1, 1, 4'h0, "p_tl_c1");
    expect_read(C1 + 4,  32'hFFFFFFFD, 1, 1, 4'h0, "p_tl_c2");
    expect_read(C1 + 4,  32'hFFFFFFFE, 1, 1, 4'h0, "p_tl_c3");
    expect_read(C1 + 4,  32'hFFFFFFFF, 1, 1, 4'h0, "p_tl_c4");
    expect_read(C1 + 12, 32'h1,        1, 1, 4'h2, "p_pend_c5");
    expect_read(SUM,     32'h2,        1, 1, 4'h2, "p_summary");
    do_write(C1 + 12, 32'h1, 1, "p_w1c");
    expect_read(C1 + 12, 32'h0,        1, 1, 4'h0, "p_cleared");
    expect_read(C1 + 4,  32'hFFFFFFFC, 1, 1, 4'h2, "p_second_reload");
    do_write(C1 + 8, 32'h0, 1, "p_disable");
    expect_read(C1 + 4,  32'hFFFFFFFE, 1, 1, 4'h0, "p_frozen1");
    expect_read(C1 + 4,  32'hFFFFFFFE, 1, 1, 4'h0, "p_frozen2");
    do_write(C1 + 12, 32'h1, 1, "p_w1c2");

    // One-shot channel 0 with IE clear.
    do_write(C0 + 0, 32'hFFFFFFFE, 1, "os_th");
    do_write(C0 + 8, 32'h5, 1, "os_tcon");
    expect_read(C0 + 4,  32'hFFFFFFFF, 1, 1, 4'h0, "os_tl_pre");
    expect_read(C0 + 8,  32'h4,        1, 1, 4'h0, "os_tcon_cleared");
    expect_read(C0 + 4,  32'hFFFFFFFE, 1, 1, 4'h0, "os_tl_reload");
    expect_read(C0 + 4,  32'hFFFFFFFE, 1, 1, 4'h0, "os_tl_frozen");
    expect_read(C0 + 12, 32'h1,        1, 1, 4'h0, "os_pend");
    expect_read(SUM,     32'h1,        1, 1, 4'h0, "os_summary");
    do_write(C0 + 12, 32'h1, 1, "os_w1c");

    // W1C against overflow on channel 2, period 2.
    do_write(C2 + 0, 32'hFFFFFFFE, 1, "w1c_th");
    do_write(C2 + 4, 32'hFFFFFFFE, 1, "w1c_tl");
    do_write(C2 + 8, 32'h3, 1, "w1c_tcon");
    expect_read(C2 + 4, 32'hFFFFFFFE, 1, 1, 4'h0, "w1c_tl");
    do_write(C2 + 12, 32'h1, 1, "w1c_collide");
    read_write(C2 + 12, 32'h1, 32'h1, 4'h4, "w1c_pend_kept");
    expect_read(C2 + 12, 32'h0, 1, 1, 4'h0, "w1c_cleared");
    do_write(C2 + 8, 32'h0, 1, "w1c_disable");
    do_write(C2 + 12, 32'h1, 1, "w1c_final");
    expect_read(SUM, 32'h0, 1, 1, 4'h0, "w1c_summary");

    // Channel 3 collisions: TL write vs reload, then TH write vs reload.
    do_write(C3 + 0, 32'h100, 1, "col_th");
    do_write(C3 + 8, 32'h3, 1, "col_tcon");
    do_write(C3 + 4, 32'h10, 1, "col_tl_wr");
    expect_read(C3 + 4, 32'h10, 1, 1, 4'h8, "col_tl");
    expect_read(C3 + 4, 32'h11, 1, 1, 4'h8, "col_tl_inc");
    do_write(C3 + 12, 32'h1, 1, "col_w1c");
    do_write(C3 + 4, 32'hFFFFFFFE, 1, "th_col_tl_wr");
    expect_read(C3 + 4, 32'hFFFFFFFE, 1, 1, 4'h0, "th_col_pre");
    do_write(C3 + 0, 32'h55, 1, "th_col_th_wr");
    expect_read(C3 + 4, 32'h100, 1, 1, 4'h8, "th_col_tl");
    expect_read(C3 + 0, 32'h55,  1, 1, 4'h8, "th_col_th");

    // Reset mid-count with every channel running, write strobe ignored.
    do_write(C0 + 8, 32'h3, 1, "rm_en0");
    do_write(C1 + 8, 32'h3, 1, "rm_en1");
    do_write(C2 + 8, 32'h3, 1, "rm_en2");
    do_write(C0 + 4, 32'h5, 1, "rm_reset_wr", 1'b0);
    expect_read(C0 + 4, 32'hFFFFFFFF, 1, 1, 4'h0, "rm_tl0");
    expect_read(C0 + 8, 32'h0,        1, 1, 4'h0, "rm_tcon0");
    expect_read(C3 + 4, 32'hFFFFFFFF, 1, 1, 4'h0, "rm_tl3");
    expect_read(C3 + 4, 32'hFFFFFFFF, 1, 1, 4'h0, "rm_tl3_static");
    expect_read(C3 + 0, 32'h0,        1, 1, 4'h0, "rm_th3");
    expect_read(SUM,    32'h0,        1, 1, 4'h0, "rm_summary");

    // Narrow two-channel build.
    sel8 = 1'b1;
    do_write(C0 + 0, 32'h1234, 1, "w8_th");
    expect_read(C0 + 0, 32'h34, 1, 0, 4'h0, "w8_th_trunc");
    expect_read(C0 + 4, 32'hFF, 1, 0, 4'h0, "w8_tl_rst");
    do_write(C1 + 4, 32'hABCDEF80, 1, "w8_tl");
    expect_read(C1 + 4, 32'h80, 1, 0, 4'h0, "w8_tl_trunc");
    expect_read(32'h40000120, 32'h0, 1, 0, 4'h0, "w8_summary");
    expect_read(32'h40000130, 32'h0, 0, 0, 4'h0, "w8_unmapped");
    do_write(32'h40000120, 32'h1, 0, "w8_summary_wr");

    apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    checks++;
    if (exp_rdata.size() == 0 && exp_wacc.size() == 0) passed++;
    else $display("[TB] FAIL queue_drain: reads left=%0d writes left=%0d, expected 0 and 0",
                  exp_rdata.size(), exp_wacc.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
